sqrt_iterative_param: RTL and testbench

//  Parametrised iterative integer square-root unit: FSM and datapath in one block.

---
 rtl/sqrt_if.sv | 25 ++
 rtl/sqrt_iterative_param.sv | 117 +++++++++++
 tb/tb_sqrt_iterative_param.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_if.sv
// Start/ready/done handshake bundle for the iterative square-root unit.
// The master side drives the request. The slave side returns status and results.
interface sqrt_if #(
    parameter int WIDTH = 16
);
    localparam int RW = WIDTH / 2;

    logic             start_i;
    logic [WIDTH-1:0] radicand_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [RW-1:0]    root_o;
    logic [RW:0]      rem_o;

    modport master (
        output start_i, radicand_i,
        input  ready_o, busy_o, done_o, root_o, rem_o
    );

    modport slave (
        input  start_i, radicand_i,
        output ready_o, busy_o, done_o, root_o, rem_o
    );
endinterface

// File: rtl/sqrt_iterative_param.sv
// Iterative integer square root: root = floor(sqrt(x)) and rem = x - root^2.
// Restoring bit-pair method with one root bit per clock and fixed latency.
module sqrt_iterative_param #(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    sqrt_if.slave bus
);
    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("sqrt_iterative_param: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] x_sh_reg;
    logic [RW+1:0]    acc_reg;
    logic [RW-1:0]    root_work_reg;
    logic [RW-1:0]    root_reg;
    logic [RW:0]      rem_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;

    // One iteration: bring down the next bit pair and try subtracting {root, 01}.
    logic [RW+3:0] trial_a;
    logic [RW+3:0] trial_t;
    logic [RW+3:0] trial_diff;
    logic          fits;
    logic [RW+1:0] acc_next;
    logic [RW-1:0] root_next;

    always_comb begin
        trial_a    = {acc_reg, x_sh_reg[WIDTH-1 -: 2]};
        trial_t    = {2'b00, root_work_reg, 2'b01};
        trial_diff = trial_a - trial_t;
        fits       = (trial_a >= trial_t);
        acc_next   = fits ? trial_diff[RW+1:0] : trial_a[RW+1:0];
        root_next  = {root_work_reg[RW-2:0], fits};
    end

    // The remainder never exceeds 2*root, so the top difference bits are always zero.
    logic unused_diff_bits;
    assign unused_diff_bits = ^trial_diff[RW+3:RW+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            x_sh_reg      <= '0;
            acc_reg       <= '0;
            root_work_reg <= '0;
            root_reg      <= '0;
            rem_reg       <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start_i) begin
                        x_sh_reg      <= bus.radicand_i;
                        acc_reg       <= '0;
                        root_work_reg <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= CALC;
                        ready_reg     <= 1'b0;
                        busy_reg      <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                CALC: begin
                    x_sh_reg      <= {x_sh_reg[WIDTH-3:0], 2'b00};
                    acc_reg       <= acc_next;
                    root_work_reg <= root_next;
                    if (cnt_reg == CW'(RW - 1)) begin
                        state_reg <= DONE;
                        root_reg  <= root_next;
                        rem_reg   <= acc_next[RW:0];
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_reg;
    assign bus.busy_o  = busy_reg;
    assign bus.done_o  = done_reg;
    assign bus.root_o  = root_reg;
    assign bus.rem_o   = rem_reg;
endmodule

// File: tb/tb_sqrt_iterative_param.sv
// Scoreboarded bench for sqrt_iterative_param: directed cases on WIDTH=16,
// plus random radicands on WIDTH=8, 16 and 32 checked against a reference root.
module tb_sqrt_iterative_param;
    localparam int W  = 16;
    localparam int RW = W / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit go_aux = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r;
        r = longint'($sqrt(real'(x)));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    sqrt_if #(.WIDTH(W)) sif ();
    sqrt_iterative_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(sif.slave));

    longint exp_q[$];
    int     done_count = 0;
    int     edges = 0;

    // Edges since accept, counting the accept edge itself.
    always @(posedge clk) begin
        if (rst) edges = 0;
        else if (sif.start_i && sif.ready_o) edges = 1;
        else edges++;
    end

    always @(negedge clk) begin
        longint x;
        longint r;
        if (!rst) begin
            check("ready_busy_excl", 64'(sif.ready_o & sif.busy_o), 64'(0));
            if (sif.done_o) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_done", 64'(1), 64'(0));
                end else begin
                    x = exp_q.pop_front();
                    r = isqrt(x);
                    $display("w16 x=%0d root=%0d rem=%0d latency=%0d", x, sif.root_o, sif.rem_o, edges);
                    check("root16", 64'(sif.root_o), 64'(r));
                    check("rem16", 64'(sif.rem_o), 64'(x - r * r));
                    check("latency16", 64'(edges), 64'(RW + 1));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!sif.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic drive(input longint x);
        wait_ready();
        sif.start_i    = 1'b1;
        sif.radicand_i = W'(x);
        exp_q.push_back(x);
        @(negedge clk);
        sif.start_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // Random checks on the other widths, each with its own instance and scoreboard.
    for (genvar gi = 0; gi < 2; gi++) begin : g_aux
        localparam int AW = (gi == 0) ? 8 : 32;
        sqrt_if #(.WIDTH(AW)) aif ();
        sqrt_iterative_param #(.WIDTH(AW)) adut (.clk(clk), .rst(rst), .bus(aif.slave));
        longint aq[$];
        bit fin = 1'b0;

        initial begin
            logic [AW-1:0] xv;
            int n;
            aif.start_i    = 1'b0;
            aif.radicand_i = '0;
            wait (go_aux);
            @(negedge clk);
            for (int i = 0; i < 30; i++) begin
                xv = (i == 0) ? '1 : (i == 1) ? '0 : AW'($urandom);
                n = 0;
                while (!aif.ready_o && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) check("aux_ready_timeout", 64'(0), 64'(1));
                aif.start_i    = 1'b1;
                aif.radicand_i = xv;
                aq.push_back(longint'(xv));
                @(negedge clk);
                aif.start_i = 1'b0;
            end
            n = 0;
            while (aq.size() != 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("aux_drain", 64'(aq.size()), 64'(0));
            fin = 1'b1;
        end

        always @(negedge clk) begin
            longint x;
            longint r;
            if (!rst && aif.done_o) begin
                if (aq.size() == 0) begin
                    check("aux_spurious_done", 64'(1), 64'(0));
                end else begin
                    x = aq.pop_front();
                    r = isqrt(x);
                    $display("w%0d x=%0d root=%0d rem=%0d", AW, x, aif.root_o, aif.rem_o);
                    check("root_aux", 64'(aif.root_o), 64'(r));
                    check("rem_aux", 64'(aif.rem_o), 64'(x - r * r));
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        sif.start_i    = 1'b0;
        sif.radicand_i = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(sif.ready_o), 64'(1));
        check("rst_busy", 64'(sif.busy_o), 64'(0));
        check("rst_done", 64'(sif.done_o), 64'(0));
        check("rst_root", 64'(sif.root_o), 64'(0));
        check("rst_rem", 64'(sif.rem_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Small and perfect-square radicands, then results held while idle.
        drive(0); drive(1); drive(144); drive(143);
        drain();
        repeat (3) @(negedge clk);
        check("hold_root", 64'(sif.root_o), 64'(11));
        check("hold_rem", 64'(sif.rem_o), 64'(22));

        // Full-scale boundaries.
        drive(65535); drive(65025);
        drain();

        // start held high: every DONE cycle must accept the next radicand.
        base = done_count;
        sif.start_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            sif.radicand_i = (i % 2 == 1) ? W'(99) : W'(100);
            exp_q.push_back((i % 2 == 1) ? 99 : 100);
            @(negedge clk);
        end
        sif.start_i = 1'b0;
        drain();
        check("b2b_count", 64'(done_count - base), 64'(6));

        // A start during CALC is ignored; the running result completes.
        base = done_count;
        drive(1000);
        repeat (2) @(negedge clk);
        sif.start_i    = 1'b1;
        sif.radicand_i = W'(4);
        @(negedge clk);
        sif.start_i = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("midcalc_count", 64'(done_count - base), 64'(1));

        // Reset mid-CALC aborts with no done.
        drive(50000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 64'(sif.ready_o), 64'(1));
        check("abort_busy", 64'(sif.busy_o), 64'(0));
        check("abort_done", 64'(sif.done_o), 64'(0));
        check("abort_root", 64'(sif.root_o), 64'(0));
        rst = 1'b0;
        exp_q.delete();
        base = done_count;
        repeat (15) @(negedge clk);
        check("abort_no_done", 64'(done_count - base), 64'(0));

        // Random radicands on all widths.
        go_aux = 1'b1;
        for (int i = 0; i < 40; i++) drive(longint'($urandom_range(65535, 0)));
        drain();
        n = 0;
        while (!(g_aux[0].fin && g_aux[1].fin) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("aux_finished", 64'(g_aux[0].fin && g_aux[1].fin), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
